// File: rtl/exu_muldiv_ctrl_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
// Info-bus field indices, FSM states and result-select codes.
package exu_muldiv_ctrl_pkg;

  localparam int MD_XLEN              = 32;
  localparam int RFIDX_WIDTH          = 5;
  localparam int DECINFO_MULDIV_WIDTH = 8;

  localparam int DECINFO_MULDIV_MUL    = 0;
  localparam int DECINFO_MULDIV_MULH   = 1;
  localparam int DECINFO_MULDIV_MULHSU = 2;
  localparam int DECINFO_MULDIV_MULHU  = 3;
  localparam int DECINFO_MULDIV_DIV    = 4;
  localparam int DECINFO_MULDIV_DIVU   = 5;
  localparam int DECINFO_MULDIV_REM    = 6;
  localparam int DECINFO_MULDIV_REMU   = 7;

  typedef enum logic [1:0] {
    MULDIV_ST_IDLE,
    MULDIV_ST_EXEC,
    MULDIV_ST_FIXUP,
    MULDIV_ST_WBCK
  } muldiv_st_e;

  typedef enum logic [1:0] {
    RES_LO,
    RES_HI,
    RES_QUO,
    RES_REM
  } res_sel_e;

endpackage

// File: rtl/exu_muldiv_ctrl_step.sv
// One radix-2 iteration: shift-add for multiply (acc = {hi, multiplier}),
// restoring subtract for divide (acc = {remainder, dividend/quotient}).
module exu_muldiv_ctrl_step #(
  parameter int XLEN = 32
) (
  input  logic              is_mul_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] top;
  logic [XLEN:0] diff;

  // Both families evaluated; the op class picks one.
  always_comb begin
    sum  = {1'b0, acc_i[2*XLEN-1:XLEN]};
    if (acc_i[0]) sum = sum + {1'b0, b_i};
    top  = acc_i[2*XLEN-1:XLEN-1];
    diff = top - {1'b0, b_i};
    if (is_mul_i)
      acc_o = {sum, acc_i[XLEN-1:1]};
    else if (!diff[XLEN])
      acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    else
      acc_o = {acc_i[2*XLEN-2:0], 1'b0};
  end

endmodule

// File: rtl/exu_muldiv_ctrl.sv
// Iterative RV32M mul/div sequencer: IDLE -> EXEC -> FIXUP -> WBCK.
// Optional MULDIV_B2B_EN reuses the last raw result for a paired op.
module exu_muldiv_ctrl
  import exu_muldiv_ctrl_pkg::*;
#(
  parameter int XLEN   = MD_XLEN,
  parameter int INFO_W = DECINFO_MULDIV_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [INFO_W-1:0]      i_info,
  input  logic [XLEN-1:0]        i_rs1,
  input  logic [XLEN-1:0]        i_rs2,
  input  logic [RFIDX_WIDTH-1:0] i_rdidx,
  input  logic                   i_flush,
  output logic                   o_busy,
  output logic                   o_wbck_valid,
  input  logic                   i_wbck_ready,
  output logic [XLEN-1:0]        o_wbck_wdat,
  output logic [RFIDX_WIDTH-1:0] o_wbck_rdidx
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_st_e             st_q, st_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   is_mul_q, neg_q;
  res_sel_e               sel_q, sel_d;
  logic [2*XLEN-1:0]      acc_q, acc_nxt, acc_init, prod;
  logic [XLEN-1:0]        b_q, wdat_q, res, spec_res;
  logic [RFIDX_WIDTH-1:0] rdidx_q;

  logic op_mul, op_mulh, op_mulhsu, op_mulhu;
  logic op_div, op_divu, op_rem, op_remu;
  logic is_mul, rs1_sgn, rs2_sgn, a_neg, b_neg, neg_d;
  logic div0, ovf, special, accept, hit;
  logic [XLEN-1:0] a_abs, b_abs;

  assign op_mul    = i_info[DECINFO_MULDIV_MUL];
  assign op_mulh   = i_info[DECINFO_MULDIV_MULH];
  assign op_mulhsu = i_info[DECINFO_MULDIV_MULHSU];
  assign op_mulhu  = i_info[DECINFO_MULDIV_MULHU];
  assign op_div    = i_info[DECINFO_MULDIV_DIV];
  assign op_divu   = i_info[DECINFO_MULDIV_DIVU];
  assign op_rem    = i_info[DECINFO_MULDIV_REM];
  assign op_remu   = i_info[DECINFO_MULDIV_REMU];

  // MUL's low half is sign-agnostic, so it shares MULH's signed class.
  assign is_mul  = op_mul | op_mulh | op_mulhsu | op_mulhu;
  assign rs1_sgn = op_mul | op_mulh | op_mulhsu | op_div | op_rem;
  assign rs2_sgn = op_mul | op_mulh | op_div | op_rem;
  assign a_neg   = rs1_sgn & i_rs1[XLEN-1];
  assign b_neg   = rs2_sgn & i_rs2[XLEN-1];
  assign a_abs   = a_neg ? -i_rs1 : i_rs1;
  assign b_abs   = b_neg ? -i_rs2 : i_rs2;
  assign neg_d   = (op_rem | op_remu) ? a_neg : (a_neg ^ b_neg);

  assign div0    = ~is_mul & (i_rs2 == '0);
  assign ovf     = (op_div | op_rem) & (i_rs1 == SMIN) & (&i_rs2);
  assign special = div0 | ovf;
  assign accept  = i_valid & o_ready;

  // Result class decoded from the one-hot info bus.
  always_comb begin
    sel_d = RES_LO;
    unique case (1'b1)
      op_mul:                        sel_d = RES_LO;
      op_mulh, op_mulhsu, op_mulhu:  sel_d = RES_HI;
      op_div, op_divu:               sel_d = RES_QUO;
      op_rem, op_remu:               sel_d = RES_REM;
      default:                       sel_d = RES_LO;
    endcase
  end

  // Short-circuit results for divide-by-zero and signed overflow.
  always_comb begin
    spec_res = '0;
    if (div0)
      spec_res = (op_div | op_divu) ? '1 : i_rs1;
    else if (op_div)
      spec_res = SMIN;
  end

`ifdef MULDIV_B2B_EN
  logic [2:0]        cls_d, cls_q, b2b_cls_q;
  logic [XLEN-1:0]   rs1_q, rs2_q, b2b_rs1_q, b2b_rs2_q;
  logic [2*XLEN-1:0] b2b_acc_q;
  logic              b2b_vld_q;

  assign cls_d = {is_mul, rs1_sgn, rs2_sgn};
  assign hit   = b2b_vld_q & (b2b_cls_q == cls_d) &
                 (b2b_rs1_q == i_rs1) & (b2b_rs2_q == i_rs2);
  assign acc_init = hit ? b2b_acc_q : {{XLEN{1'b0}}, a_abs};

  // Capture tags on accept; keep the raw result once FIXUP is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      b2b_cls_q <= '0;
      b2b_rs1_q <= '0;
      b2b_rs2_q <= '0;
      b2b_acc_q <= '0;
      b2b_vld_q <= 1'b0;
    end else if (i_flush) begin
      b2b_vld_q <= 1'b0;
    end else begin
      if (accept) begin
        cls_q <= cls_d;
        rs1_q <= i_rs1;
        rs2_q <= i_rs2;
      end
      if (st_q == MULDIV_ST_FIXUP) begin
        b2b_vld_q <= 1'b1;
        b2b_cls_q <= cls_q;
        b2b_rs1_q <= rs1_q;
        b2b_rs2_q <= rs2_q;
        b2b_acc_q <= acc_q;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign acc_init = {{XLEN{1'b0}}, a_abs};
`endif

  exu_muldiv_ctrl_step #(.XLEN(XLEN)) u_step (
    .is_mul_i (is_mul_q),
    .acc_i    (acc_q),
    .b_i      (b_q),
    .acc_o    (acc_nxt)
  );

  // Sign correction and half/quotient/remainder selection.
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    res  = '0;
    unique case (sel_q)
      RES_LO:  res = prod[XLEN-1:0];
      RES_HI:  res = prod[2*XLEN-1:XLEN];
      RES_QUO: res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      RES_REM: res = neg_q ? -acc_q[2*XLEN-1:XLEN]
                           : acc_q[2*XLEN-1:XLEN];
      default: res = '0;
    endcase
  end

  assign cnt_d = (st_q == MULDIV_ST_EXEC && !i_flush && cnt_q != CNT_LAST)
               ? cnt_q + 1'b1 : '0;

  // State and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= MULDIV_ST_IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state; flush overrides everything.
  always_comb begin
    st_d = st_q;
    if (i_flush) begin
      st_d = MULDIV_ST_IDLE;
    end else begin
      unique case (st_q)
        MULDIV_ST_IDLE:
          if (i_valid)
            st_d = special ? MULDIV_ST_WBCK :
                   hit     ? MULDIV_ST_FIXUP : MULDIV_ST_EXEC;
        MULDIV_ST_EXEC:
          if (cnt_q == CNT_LAST) st_d = MULDIV_ST_FIXUP;
        MULDIV_ST_FIXUP:
          st_d = MULDIV_ST_WBCK;
        MULDIV_ST_WBCK:
          if (i_wbck_ready) st_d = MULDIV_ST_IDLE;
        default:
          st_d = MULDIV_ST_IDLE;
      endcase
    end
  end

  // Handshake outputs; a flush also masks a pending writeback.
  always_comb begin
    o_ready      = (st_q == MULDIV_ST_IDLE) & ~i_flush;
    o_busy       = (st_q != MULDIV_ST_IDLE);
    o_wbck_valid = (st_q == MULDIV_ST_WBCK) & ~i_flush;
  end

  // Operand capture, iteration and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdidx_q  <= '0;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      sel_q    <= RES_LO;
      b_q      <= '0;
      acc_q    <= '0;
      wdat_q   <= '0;
    end else if (accept) begin
      rdidx_q  <= i_rdidx;
      is_mul_q <= is_mul;
      neg_q    <= neg_d;
      sel_q    <= sel_d;
      b_q      <= b_abs;
      acc_q    <= acc_init;
      if (special) wdat_q <= spec_res;
    end else if (st_q == MULDIV_ST_EXEC) begin
      acc_q <= acc_nxt;
    end else if (st_q == MULDIV_ST_FIXUP && !i_flush) begin
      wdat_q <= res;
    end
  end

  assign o_wbck_wdat  = wdat_q;
  assign o_wbck_rdidx = rdidx_q;

endmodule

// File: tb/tb_exu_muldiv_ctrl.sv
// Directed scoreboard bench for exu_muldiv_ctrl.
// Build with MULDIV_B2B_EN to expect the short paired-op latency.
module tb_exu_muldiv_ctrl;
  import exu_muldiv_ctrl_pkg::*;

`ifdef MULDIV_B2B_EN
  localparam int B2B_LAT = 2;
`else
  localparam int B2B_LAT = 34;
`endif
  localparam int LAT = 34;

  localparam logic [7:0] I_MUL    = 8'h01;
  localparam logic [7:0] I_MULH   = 8'h02;
  localparam logic [7:0] I_MULHU  = 8'h08;
  localparam logic [7:0] I_DIV    = 8'h10;
  localparam logic [7:0] I_DIVU   = 8'h20;
  localparam logic [7:0] I_REM    = 8'h40;
  localparam logic [7:0] I_REMU   = 8'h80;

  logic        clk, rst_n;
  logic        i_valid, o_ready, i_flush, o_busy;
  logic [7:0]  i_info;
  logic [31:0] i_rs1, i_rs2, o_wbck_wdat;
  logic [4:0]  i_rdidx, o_wbck_rdidx;
  logic        o_wbck_valid, i_wbck_ready;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  int ntests = 0;
  int nfail  = 0;

  exu_muldiv_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_info       (i_info),
    .i_rs1        (i_rs1),
    .i_rs2        (i_rs2),
    .i_rdidx      (i_rdidx),
    .i_flush      (i_flush),
    .o_busy       (o_busy),
    .o_wbck_valid (o_wbck_valid),
    .i_wbck_ready (i_wbck_ready),
    .o_wbck_wdat  (o_wbck_wdat),
    .o_wbck_rdidx (o_wbck_rdidx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] info, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] d, input int lat);
    exp_t e;
    @(negedge clk);
    chk("ready_before_issue", 64'(o_ready), 64'd1);
    i_valid = 1'b1;
    i_info  = info;
    i_rs1   = a;
    i_rs2   = b;
    i_rdidx = rd;
    e.d = d; e.rd = rd; e.lat = lat;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_info  = '0;
  endtask

  task automatic result(input string tag, input int hold);
    int   n;
    bit   got;
    exp_t e;
    n = 0;
    got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (o_wbck_valid === 1'b1) got = 1;
    end
    e = sbq.pop_front();
    chk({tag, "/valid"}, 64'(got), 64'd1);
    chk({tag, "/latency"}, 64'(n), 64'(e.lat));
    chk({tag, "/data"}, 64'(o_wbck_wdat), 64'(e.d));
    chk({tag, "/rdidx"}, 64'(o_wbck_rdidx), 64'(e.rd));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "/hold_valid"}, 64'(o_wbck_valid), 64'd1);
      chk({tag, "/hold_data"}, 64'(o_wbck_wdat), 64'(e.d));
      chk({tag, "/hold_rd"}, 64'(o_wbck_rdidx), 64'(e.rd));
      chk({tag, "/hold_ready"}, 64'(o_ready), 64'd0);
    end
    i_wbck_ready = 1'b1;
    @(posedge clk);
    #1;
    i_wbck_ready = 1'b0;
    @(negedge clk);
    chk({tag, "/idle_after"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    longint      p;
    logic [63:0] pv;
    int          pulses;

    rst_n = 1'b0;
    i_valid = 1'b0; i_info = '0; i_rs1 = '0; i_rs2 = '0;
    i_rdidx = '0; i_flush = 1'b0; i_wbck_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_valid", 64'(o_wbck_valid), 64'd0);
    chk("rst_wdat", 64'(o_wbck_wdat), 64'd0);
    chk("rst_rdidx", 64'(o_wbck_rdidx), 64'd0);
    #2 rst_n = 1'b1;

    issue(I_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, LAT);
    result("mul_7x-3", 0);
    issue(I_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, LAT);
    result("mulhu_max", 0);

    issue(I_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, LAT);
    result("div_-7/2", 0);
    issue(I_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, B2B_LAT);
    result("rem_-7/2", 0);
    issue(I_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, LAT);
    result("divu_100/7", 0);
    issue(I_REMU, 32'd100, 32'd7, 5'd6, 32'd2, B2B_LAT);
    result("remu_100/7", 0);

    issue(I_DIVU, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 1);
    result("divu_by0", 0);
    issue(I_REMU, 32'd9, 32'd0, 5'd8, 32'd9, 1);
    result("remu_by0", 0);
    issue(I_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1);
    result("div_ovf", 0);
    issue(I_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 1);
    result("rem_ovf", 0);

    issue(I_MUL, 32'd3, 32'd5, 5'd11, 32'd15, LAT);
    result("mul_hold", 5);

    issue(I_MUL, 32'h1234, 32'h5678, 5'd12, 32'd0, LAT);
    void'(sbq.pop_back());
    repeat (10) @(negedge clk);
    chk("flush_pre_busy", 64'(o_busy), 64'd1);
    i_flush = 1'b1;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(o_busy), 64'd0);
    chk("flush_ready", 64'(o_ready), 64'd1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_wbck_valid !== 1'b0) pulses++;
    end
    chk("flush_no_wbck", 64'(pulses), 64'd0);
    issue(I_MUL, 32'd3, 32'd4, 5'd13, 32'd12, LAT);
    result("mul_after_flush", 0);

    issue(I_DIVU, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1);
    void'(sbq.pop_back());
    @(negedge clk);
    chk("wbck_flush_pre", 64'(o_busy), 64'd1);
    i_flush = 1'b1;
    i_wbck_ready = 1'b1;
    #1;
    chk("wbck_flush_valid", 64'(o_wbck_valid), 64'd0);
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    i_wbck_ready = 1'b0;
    @(negedge clk);
    chk("wbck_flush_idle", 64'(o_busy), 64'd0);
    chk("wbck_flush_nov", 64'(o_wbck_valid), 64'd0);

    @(negedge clk);
    i_valid = 1'b1; i_info = I_MUL; i_flush = 1'b1;
    #1;
    chk("idle_flush_ready", 64'(o_ready), 64'd0);
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_info = '0; i_flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_noacc", 64'(o_busy), 64'd0);

    p  = longint'($signed(32'h1234_5678)) * longint'($signed(32'h9ABC_DEF0));
    pv = p;
    issue(I_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, pv[63:32], LAT);
    result("mulh_pair", 0);
    issue(I_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd16, pv[31:0], B2B_LAT);
    result("mul_pair", 0);

    if (sbq.size() != 0) begin
      ntests++;
      nfail++;
      $display("FAIL scoreboard_left: observed %0d expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exu_muldiv_ctrl.md
Name: exu_muldiv_ctrl

Overview:
- Iterative multiply/divide unit and its sequencer for the RV32M subset.
- Accepts one MULDIV-group instruction at a time from the dispatch stage, using the decoded MULDIV info bus and the rs1/rs2 values.
- Steps a shared radix-2 shift/add-subtract datapath over XLEN cycles, then presents the result to the writeback arbiter.
- Sits beside the 1-cycle ALU in the execute stage.

Parameters:
- XLEN, 32, operand and result width; the counter is clog2(XLEN)+1 bits.
- INFO_W, `DECINFO_MULDIV_WIDTH, width of the decoded info bus.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  dispatch offers an instruction
- o_ready  out  1  unit can accept an instruction
- i_info  in  INFO_W  MULDIV info bus (one-hot MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
- i_rs1  in  XLEN  operand 1
- i_rs2  in  XLEN  operand 2
- i_rdidx  in  `RFIDX_WIDTH  destination register index
- i_flush  in  1  pipeline flush; kills any in-flight operation
- o_busy  out  1  operation in flight (to the dependency check)
- o_wbck_valid  out  1  result valid
- i_wbck_ready  in  1  writeback accepts the result
- o_wbck_wdat  out  XLEN  result
- o_wbck_rdidx  out  `RFIDX_WIDTH  destination index

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, o_ready=1, o_busy=0, o_wbck_valid=0, o_wbck_wdat=0, o_wbck_rdidx=0, counter=0.
- States: IDLE, EXEC, FIXUP, WBCK.
- Handshake: o_ready = (state==IDLE) & ~i_flush. Accept = i_valid & o_ready.
- Accept latches the following, then goes to EXEC and clears the counter:
  - the op;
  - rdidx;
  - absolute values of the operands; rs1 is signed for MULH/MULHSU/DIV/REM, rs2 is signed for MULH/DIV/REM;
  - result-sign flags.
- Special cases on accept skip EXEC and load the result straight into WBCK, so o_wbck_valid is high the next cycle:
  - divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- EXEC, one iteration per cycle for XLEN cycles; at counter==XLEN-1, go to FIXUP.
  - MUL family: shift-add into a 2*XLEN accumulator.
  - DIV family: restoring subtract; quotient and remainder registers.
- FIXUP: 1 cycle.
  - Conditionally negate the product, quotient or remainder. Remainder takes the sign of the dividend.
  - Select the result: MUL takes the low half, MULH* the high half, DIV* the quotient, REM* the remainder.
  - Then go to WBCK.
- WBCK: o_wbck_valid=1, with data and rdidx held stable until i_wbck_ready. On the handshake, go to IDLE. No accept in the same cycle.
- Normal latency: accept at cycle 0, o_wbck_valid at cycle XLEN+2 (34).
- o_busy = (state != IDLE).
- i_flush:
  - in any state: go to IDLE next cycle, o_wbck_valid drops, no result is written, counter cleared;
  - in WBCK with i_wbck_ready also high: flush wins, no writeback;
  - in IDLE: blocks acceptance that cycle.
- Arithmetic wraps modulo 2^XLEN; no exceptions are raised.

Optional Feature:
- Macro: MULDIV_B2B_EN.
- With the macro:
  - After each completed op, keep the raw results and tags: full 2*XLEN product or quotient+remainder, plus the operand values and the signedness class.
  - A new op of the same family and class with identical i_rs1/i_rs2 (MULH*→MUL, DIV↔REM, DIVU↔REMU) bypasses EXEC: accept → FIXUP → WBCK, with o_wbck_valid at cycle 2.
  - Flush or reset invalidates the stored results.
- Without the macro: no result storage; every op takes full latency.

Decomposition:
- defines.v: XLEN, RFIDX_WIDTH, DECINFO_MULDIV_* field indices, state encodings (MULDIV_ST_IDLE/EXEC/FIXUP/WBCK).
- One sub-module, exu_muldiv_step: combinational single-iteration add/subtract-and-shift for both families, instantiated once. The FSM, counter and fixup stay in exu_muldiv_ctrl.

Test Plan:
- MUL 7×(-3): i_rs1=7, i_rs2=0xFFFFFFFD → o_wbck_wdat=0xFFFFFFEB at cycle 34. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF at cycle 1; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Hold i_wbck_ready=0 for 5 cycles in WBCK → data and rdidx stable, o_ready=0. Release → IDLE, and the next accept proceeds.
- i_flush at EXEC cycle 10 → IDLE next cycle, no o_wbck_valid pulse; the following MUL 3×4 → 12.
- With MULDIV_B2B_EN: MULH 0x12345678×0x9ABCDEF0, then MUL with the same operands → second result valid 2 cycles after accept, equal to the low half. Same pair without the macro → 34 cycles.
